// File: rtl/counter_scheduler_pkg.sv
// Shared types for the counter scheduler.
// FSM state encoding and a width helper.
package counter_scheduler_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/counter_scheduler_rr_arbiter.sv
// Combinational round-robin pick.
// First set request at or after the pointer wins.
module rr_arbiter
  import counter_scheduler_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PW    = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PW-1:0]    i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [PW-1:0]    o_idx,
  output logic             o_valid
);

  // scan upward from the pointer, wrapping mod N_REQ
  always_comb begin
    int j;
    j       = 0;
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      j = (int'(i_ptr) + k) % N_REQ;
      if (!o_valid && i_req[j]) begin
        o_valid    = 1'b1;
        o_grant[j] = 1'b1;
        o_idx      = PW'(j);
      end
    end
  end

endmodule

// File: rtl/counter_scheduler.sv
// Shares one external up-counter among requesters.
// Grants round-robin, loads start, counts to limit.
module counter_scheduler
  import counter_scheduler_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N_REQ = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         i_req,
  input  logic [N_REQ*WIDTH-1:0]   i_start,
  input  logic [N_REQ*WIDTH-1:0]   i_limit,
  input  logic [WIDTH-1:0]         i_number,
  output logic                     o_set_en,
  output logic                     o_count_en,
  output logic [WIDTH-1:0]         o_data,
  output logic [N_REQ-1:0]         o_grant,
  output logic [N_REQ-1:0]         o_done,
  output logic                     o_busy
);

  localparam int PW = clog2(N_REQ);

  state_t           r_state;
  state_t           w_next;
  logic [PW-1:0]    r_ptr;
  logic [PW-1:0]    r_owner;
  logic [WIDTH-1:0] r_start;
  logic [WIDTH-1:0] r_limit;
  logic [PW-1:0]    w_idx;
  logic [PW-1:0]    w_owner_inc;
  logic [N_REQ-1:0] w_pick;
  logic [N_REQ-1:0] w_owner_oh;
  logic             w_valid;
  logic             w_own_req;
  logic             w_at_limit;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_arb (
    .i_req   (i_req),
    .i_ptr   (r_ptr),
    .o_grant (w_pick),
    .o_idx   (w_idx),
    .o_valid (w_valid)
  );

  assign w_own_req   = i_req[r_owner];
  assign w_at_limit  = (i_number == r_limit);
  assign w_owner_oh  = N_REQ'(1) << r_owner;
  assign w_owner_inc = (r_owner == PW'(N_REQ - 1))
                     ? '0 : r_owner + PW'(1);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // capture owner and its operands at grant time
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner <= '0;
      r_start <= '0;
      r_limit <= '0;
    end else if (r_state == S_IDLE && w_valid) begin
      r_owner <= w_idx;
      r_start <= i_start[w_idx*WIDTH +: WIDTH];
      r_limit <= i_limit[w_idx*WIDTH +: WIDTH];
    end
  end

  // pointer moves past the owner on completion or abort
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (r_state == S_DONE ||
                 (r_state == S_RUN && !w_own_req)) begin
      r_ptr <= w_owner_inc;
    end
  end

  // next state and outputs; count_en is the only Mealy output
  always_comb begin
    w_next     = r_state;
    o_set_en   = 1'b0;
    o_count_en = 1'b0;
    o_data     = '0;
    o_grant    = '0;
    o_done     = '0;
    o_busy     = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (w_valid) w_next = S_LOAD;
      end
      S_LOAD: begin
        o_grant  = w_owner_oh;
        o_set_en = 1'b1;
        o_data   = r_start;
        w_next   = S_RUN;
      end
      S_RUN: begin
        o_grant    = w_owner_oh;
        o_count_en = !w_at_limit && w_own_req;
        if (!w_own_req)     w_next = S_IDLE;
        else if (w_at_limit) w_next = S_DONE;
      end
      S_DONE: begin
        o_grant = w_owner_oh;
        o_done  = w_owner_oh;
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_counter_scheduler.sv
// Bench for counter_scheduler.
// Directed scenarios plus random episodes vs a transaction model.
module tb_counter_scheduler;

  localparam int W = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] start;
  logic [N*W-1:0] limit;
  logic [W-1:0]   number = '0;
  logic           set_en;
  logic           count_en;
  logic [W-1:0]   data;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic           busy;

  int n_vec = 0;
  int n_err = 0;
  int m_ptr = 0;
  logic [N-1:0] held = '0;
  logic [W-1:0] st [N];
  logic [W-1:0] lm [N];

  always #5 clk = ~clk;

  counter_scheduler #(.WIDTH(W), .N_REQ(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_req      (req),
    .i_start    (start),
    .i_limit    (limit),
    .i_number   (number),
    .o_set_en   (set_en),
    .o_count_en (count_en),
    .o_data     (data),
    .o_grant    (grant),
    .o_done     (done),
    .o_busy     (busy)
  );

  // external counter: synchronous load has priority over increment
  always @(posedge clk) begin
    if (set_en)        number <= data;
    else if (count_en) number <= number + 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pack_in;
    for (int i = 0; i < N; i++) begin
      start[i*W +: W] = st[i];
      limit[i*W +: W] = lm[i];
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_set"},   32'(set_en),   0);
    chk({tag, "_cnt"},   32'(count_en), 0);
    chk({tag, "_data"},  32'(data),     0);
    chk({tag, "_grant"}, 32'(grant),    0);
    chk({tag, "_done"},  32'(done),     0);
    chk({tag, "_busy"},  32'(busy),     0);
  endtask

  // One grant from the current IDLE cycle. abort_at / rst_at are
  // RUN-cycle offsets (-1 = none) where the owner drops / reset hits.
  task automatic episode(input logic [N-1:0] add, input bit keep,
                         input int abort_at, input int rst_at);
    int win;
    int k;
    logic [W-1:0] s;
    logic [W-1:0] l;
    logic [W-1:0] d;
    logic [N-1:0] oh;
    held = held | add;
    req  = held;
    pack_in();
    #1;
    chk("idle_busy",  32'(busy),  0);
    chk("idle_grant", 32'(grant), 0);
    chk("idle_done",  32'(done),  0);
    if (held == '0) begin
      tick();
      return;
    end
    win = -1;
    for (int j = 0; j < N; j++)
      if (win < 0 && held[(m_ptr + j) % N]) win = (m_ptr + j) % N;
    s  = st[win];
    l  = lm[win];
    d  = l - s;
    k  = int'(d);
    oh = N'(1) << win;
    tick();
    for (int i = 0; i < N; i++) begin
      start[i*W +: W] = W'($urandom);
      limit[i*W +: W] = W'($urandom);
    end
    #1;
    chk("load_set",   32'(set_en),   1);
    chk("load_data",  32'(data),     32'(s));
    chk("load_grant", 32'(grant),    32'(oh));
    chk("load_cnt",   32'(count_en), 0);
    chk("load_busy",  32'(busy),     1);
    for (int j = 0; j <= k; j++) begin
      tick();
      if (j == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk_zero("rst_async");
        tick();
        chk_zero("rst_hold");
        rst_n = 1'b1;
        m_ptr = 0;
        held  = '0;
        req   = '0;
        return;
      end
      if (j == abort_at) begin
        held[win] = 1'b0;
        req = held;
      end
      #1;
      chk("run_num",   32'(number),   32'(W'(s + W'(j))));
      chk("run_cnt",   32'(count_en), (j < k && j != abort_at) ? 1 : 0);
      chk("run_grant", 32'(grant),    32'(oh));
      chk("run_set",   32'(set_en),   0);
      chk("run_data",  32'(data),     0);
      chk("run_done",  32'(done),     0);
      if (j == abort_at) begin
        m_ptr = (win + 1) % N;
        tick();
        return;
      end
    end
    tick();
    #1;
    chk("done_pulse", 32'(done),     32'(oh));
    chk("done_grant", 32'(grant),    32'(oh));
    chk("done_cnt",   32'(count_en), 0);
    chk("done_busy",  32'(busy),     1);
    m_ptr = (win + 1) % N;
    if (!keep) held[win] = 1'b0;
    req = held;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    for (int i = 0; i < N; i++) begin
      st[i] = '0;
      lm[i] = '0;
    end
    pack_in();
    @(posedge clk);
    #1;
    chk_zero("reset");
    tick();
    rst_n = 1'b1;

    st[1] = 8'd3;   lm[1] = 8'd5;
    episode(4'b0010, 1'b0, -1, -1);
    st[0] = 8'd7;   lm[0] = 8'd7;
    episode(4'b0001, 1'b0, -1, -1);
    st[2] = 8'hFE;  lm[2] = 8'h01;
    episode(4'b0100, 1'b0, -1, -1);

    st[3] = 8'd10;  lm[3] = 8'd20;
    episode(4'b1000, 1'b0, -1, 4);
    #1;
    chk("post_rst_busy", 32'(busy), 0);

    for (int i = 0; i < N; i++) begin
      st[i] = W'(i * 16);
      lm[i] = W'(i * 16 + i + 1);
    end
    episode(4'b1111, 1'b1, -1, -1);
    repeat (4) episode(4'b0000, 1'b1, -1, -1);
    held = '0;
    req  = '0;

    st[2] = 8'd40;  lm[2] = 8'd48;
    st[3] = 8'd1;   lm[3] = 8'd2;
    episode(4'b1100, 1'b0, 3, -1);
    episode(4'b0001, 1'b0, -1, -1);
    held = '0;
    req  = '0;

    for (int e = 0; e < 150; e++) begin
      int ab;
      for (int i = 0; i < N; i++) begin
        st[i] = W'($urandom);
        if ($urandom_range(0, 7) == 0) lm[i] = W'($urandom);
        else lm[i] = st[i] + W'($urandom_range(0, 12));
      end
      ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1;
      episode(N'($urandom), 1'($urandom), ab, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
